// File: rtl/elastic_fifo_pkg.sv
// Shared sizing helpers for the elastic FIFO and its storage array.
package elastic_pkg;

    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_fifo_if.sv
// Valid/ready stream seen from the buffer: producer side (data_i/valid_i/ready_o)
// and consumer side (data_o/valid_o/ready_i).
interface elastic_fifo_if #(
    parameter int Width = 8
);
    logic [Width-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic [Width-1:0] data_o;
    logic             valid_o;
    logic             ready_i;

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, valid_o, data_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, valid_o, data_o
    );
endinterface

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_mem
    import elastic_pkg::*;
#(
    parameter int Width         = 8,
    parameter int Depth         = 4,
    parameter bit DatapathReset = 1'b0,
    localparam int PtrW         = ptr_width(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [PtrW-1:0]  waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [PtrW-1:0]  raddr_i,
    output logic [Width-1:0] rdata_o
);
    logic [Width-1:0] r_mem [Depth];

    // NOTE: storage only gets a reset when asked for; an unreset array maps to plain
    // flops or LUT-RAM, while a reset one forces every bit onto the reset tree.
    if (DatapathReset) begin : g_rst_mem
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_mem <= '{default: '0};
            end else if (we_i) begin
                r_mem[waddr_i] <= wdata_i;
            end
        end
    end else begin : g_norst_mem
        logic w_unused_rst;
        assign w_unused_rst = rst_ni;

        always_ff @(posedge clk_i) begin
            if (we_i) begin
                r_mem[waddr_i] <= wdata_i;
            end
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/elastic_fifo.sv
// Multi-entry elastic buffer: ready/valid come only from registered occupancy,
// so there is no combinational ready_i -> ready_o path and no fall-through.
module elastic_fifo
    import elastic_pkg::*;
#(
    parameter int Width         = 8,
    parameter int Depth         = 4,
    parameter bit DatapathReset = 1'b0,
    localparam int PtrW         = ptr_width(Depth),
    localparam int CountW       = count_width(Depth)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    elastic_fifo_if.slave     io,
    output logic [CountW-1:0] count_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam logic [PtrW-1:0]   LastPtr  = PtrW'(Depth - 1);
    localparam logic [CountW-1:0] MaxCount = CountW'(Depth);

    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CountW-1:0] r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_in_fire;
    logic              w_out_fire;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    assign w_full     = (r_count == MaxCount);
    assign w_empty    = (r_count == '0);
    assign io.ready_o = ~w_full & ~flush_i;
    assign io.valid_o = ~w_empty & ~flush_i;
    assign w_in_fire  = io.valid_i & io.ready_o;
    assign w_out_fire = io.valid_o & io.ready_i;

    assign count_o = r_count;
    assign full_o  = w_full;
    assign empty_o = w_empty;

    // NOTE: all state updates use <= so every register samples the pre-edge values
    // of its neighbours, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_in_fire) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_out_fire) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            unique case ({w_in_fire, w_out_fire})
                2'b10:   r_count <= r_count + CountW'(1);
                2'b01:   r_count <= r_count - CountW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_mem #(
        .Width         (Width),
        .Depth         (Depth),
        .DatapathReset (DatapathReset)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (w_in_fire),
        .waddr_i (r_wr_ptr),
        .wdata_i (io.data_i),
        .raddr_i (r_rd_ptr),
        .rdata_o (io.data_o)
    );

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_count <= MaxCount);
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_out_fire |-> (r_count != '0));

endmodule

// File: tb/tb_elastic_fifo.sv
// Bench for elastic_fifo at depths 4, 3 and 1; expectations come from literal
// sequences and a per-instance queue model of FIFO ordering and occupancy.
module tb_elastic_fifo;
    import elastic_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_ni;
    logic flush_i;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    elastic_fifo_if #(.Width(W)) if4 ();
    elastic_fifo_if #(.Width(W)) if3 ();
    elastic_fifo_if #(.Width(W)) if1 ();

    logic [2:0] count4;
    logic [1:0] count3;
    logic [0:0] count1;
    logic       full4, empty4, full3, empty3, full1, empty1;

    elastic_fifo #(.Width(W), .Depth(4), .DatapathReset(1'b1)) u_d4 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .io(if4),
        .count_o(count4), .full_o(full4), .empty_o(empty4));
    elastic_fifo #(.Width(W), .Depth(3), .DatapathReset(1'b0)) u_d3 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .io(if3),
        .count_o(count3), .full_o(full3), .empty_o(empty3));
    elastic_fifo #(.Width(W), .Depth(1), .DatapathReset(1'b0)) u_d1 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .io(if1),
        .count_o(count1), .full_o(full1), .empty_o(empty1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_ni = 1'b1;
        tick();
        #1;
        checks++; if (if4.valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if4.valid_o); end
        checks++; if (if4.ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", if4.ready_o); end
        checks++; if (count4 !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count4); end
        checks++; if (empty4 !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty4); end
        checks++; if (full4 !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", full4); end
        checks++; if (if4.data_o !== 8'h00) begin failures++; $display("FAIL rst_data got=%0h exp=0", if4.data_o); end
        checks++; if (if3.ready_o !== 1'b1 || count3 !== 2'd0) begin failures++; $display("FAIL rst_d3 got=%b/%0d exp=1/0", if3.ready_o, count3); end
        checks++; if (if1.ready_o !== 1'b1 || empty1 !== 1'b1) begin failures++; $display("FAIL rst_d1 got=%b/%b exp=1/1", if1.ready_o, empty1); end

        // Asynchronous reset in the middle of a burst.
        if4.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if4.valid_i = 1'b1;
            if4.data_i  = 8'hC1 + 8'(i);
            tick();
        end
        if4.valid_i = 1'b0;
        #1;
        checks++; if (count4 !== 3'd3) begin failures++; $display("FAIL burst_count got=%0d exp=3", count4); end
        #1 rst_ni = 1'b0;
        #1;
        checks++; if (count4 !== 3'd0) begin failures++; $display("FAIL async_rst_count got=%0d exp=0", count4); end
        checks++; if (if4.valid_o !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", if4.valid_o); end
        checks++; if (if4.data_o !== 8'h00) begin failures++; $display("FAIL async_rst_data got=%0h exp=0", if4.data_o); end
        @(negedge clk) rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_fill_full();
        logic [7:0] pushes [5];
        logic [7:0] got [$];
        bit         accepted = 1'b0;
        pushes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        if4.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if4.valid_i = 1'b1;
            if4.data_i  = pushes[i];
            #1;
            checks++; if (if4.ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, if4.ready_o); end
            tick();
        end
        if4.data_i = 8'h55;
        #1;
        checks++; if (count4 !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count4); end
        checks++; if (full4 !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full4); end
        checks++; if (if4.ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", if4.ready_o); end
        checks++; if (if4.data_o !== 8'h11) begin failures++; $display("FAIL full_head got=%0h exp=11", if4.data_o); end
        tick();
        checks++; if (count4 !== 3'd4 || if4.data_o !== 8'h11) begin failures++; $display("FAIL no_accept got=%0d/%0h exp=4/11", count4, if4.data_o); end

        if4.ready_i = 1'b1;
        for (int c = 0; c < 8 && got.size() < 5; c++) begin
            #1;
            if (c == 0) begin
                checks++; if (if4.ready_o !== 1'b0) begin failures++; $display("FAIL pop_full_ready got=%b exp=0", if4.ready_o); end
            end
            if (c == 1) begin
                checks++; if (if4.ready_o !== 1'b1) begin failures++; $display("FAIL ready_rise got=%b exp=1", if4.ready_o); end
            end
            if (if4.valid_o && if4.ready_i) got.push_back(if4.data_o);
            if (if4.valid_i && if4.ready_o) accepted = 1'b1;
            tick();
            if (accepted) if4.valid_i = 1'b0;
        end
        checks++; if (got.size() != 5) begin failures++; $display("FAIL drain_len got=%0d exp=5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++; if (got[i] !== pushes[i]) begin failures++; $display("FAIL drain_order[%0d] got=%0h exp=%0h", i, got[i], pushes[i]); end
        end
        checks++; if (empty4 !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty4); end
        if4.valid_i = 1'b0;
        if4.ready_i = 1'b0;
    endtask

    task automatic test_stream();
        if4.valid_i = 1'b1;
        if4.ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if4.data_i = 8'(k);
            #1;
            if (k == 0) begin
                checks++; if (if4.valid_o !== 1'b0 || count4 !== 3'd0) begin failures++; $display("FAIL stream_first got=%b/%0d exp=0/0", if4.valid_o, count4); end
            end else begin
                checks++; if (if4.valid_o !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, if4.valid_o); end
                checks++; if (if4.data_o !== 8'(k - 1)) begin failures++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", k, if4.data_o, 8'(k - 1)); end
                checks++; if (count4 !== 3'd1) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, count4); end
            end
            tick();
        end
        if4.valid_i = 1'b0;
        #1;
        checks++; if (if4.valid_o !== 1'b1 || if4.data_o !== 8'd19) begin failures++; $display("FAIL stream_last got=%b/%0h exp=1/13", if4.valid_o, if4.data_o); end
        tick();
        checks++; if (empty4 !== 1'b1) begin failures++; $display("FAIL stream_empty got=%b exp=1", empty4); end
        if4.ready_i = 1'b0;
    endtask

    task automatic test_wrap_d3();
        logic [7:0] q [$];
        logic [7:0] din;
        logic       exp_ready, exp_valid, in_f, out_f;
        int         pushed = 0;
        for (int c = 0; c < 70; c++) begin
            din         = 8'($urandom);
            if3.valid_i = (c < 60) && ($urandom_range(0, 3) != 0);
            if3.data_i  = din;
            if3.ready_i = (c >= 60) || ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = (q.size() < 3);
            exp_valid = (q.size() != 0);
            checks++; if (if3.ready_o !== exp_ready) begin failures++; $display("FAIL d3_ready[%0d] got=%b exp=%b", c, if3.ready_o, exp_ready); end
            checks++; if (if3.valid_o !== exp_valid) begin failures++; $display("FAIL d3_valid[%0d] got=%b exp=%b", c, if3.valid_o, exp_valid); end
            checks++; if (count3 !== 2'(q.size())) begin failures++; $display("FAIL d3_count[%0d] got=%0d exp=%0d", c, count3, q.size()); end
            if (exp_valid) begin
                checks++; if (if3.data_o !== q[0]) begin failures++; $display("FAIL d3_data[%0d] got=%0h exp=%0h", c, if3.data_o, q[0]); end
            end
            in_f  = if3.valid_i & exp_ready;
            out_f = exp_valid & if3.ready_i;
            tick();
            if (out_f) void'(q.pop_front());
            if (in_f) begin
                q.push_back(din);
                pushed++;
            end
        end
        checks++; if (pushed < 10 || q.size() != 0 || empty3 !== 1'b1) begin failures++; $display("FAIL d3_end got=%0d/%0d/%b exp=>=10/0/1", pushed, q.size(), empty3); end
        if3.valid_i = 1'b0;
        if3.ready_i = 1'b0;
    endtask

    task automatic test_flush();
        if4.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if4.valid_i = 1'b1;
            if4.data_i  = 8'(i + 1);
            tick();
        end
        if4.data_i  = 8'h77;
        if4.ready_i = 1'b1;
        flush_i     = 1'b1;
        #1;
        checks++; if (if4.ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", if4.ready_o); end
        checks++; if (if4.valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", if4.valid_o); end
        checks++; if (count4 !== 3'd3) begin failures++; $display("FAIL flush_count_before got=%0d exp=3", count4); end
        tick();
        flush_i     = 1'b0;
        if4.data_i  = 8'hA5;
        if4.ready_i = 1'b0;
        #1;
        checks++; if (count4 !== 3'd0 || empty4 !== 1'b1) begin failures++; $display("FAIL flush_cleared got=%0d/%b exp=0/1", count4, empty4); end
        checks++; if (if4.valid_o !== 1'b0 || if4.ready_o !== 1'b1) begin failures++; $display("FAIL post_flush_hs got=%b/%b exp=0/1", if4.valid_o, if4.ready_o); end
        tick();
        if4.valid_i = 1'b0;
        #1;
        checks++; if (count4 !== 3'd1 || if4.valid_o !== 1'b1 || if4.data_o !== 8'hA5) begin failures++; $display("FAIL flush_next_head got=%0d/%b/%0h exp=1/1/a5", count4, if4.valid_o, if4.data_o); end

        // Flush held for several cycles with both sides trying to transfer.
        if4.valid_i = 1'b1;
        if4.data_i  = 8'h5A;
        if4.ready_i = 1'b1;
        flush_i     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (if4.ready_o !== 1'b0 || if4.valid_o !== 1'b0) begin failures++; $display("FAIL held_flush_hs[%0d] got=%b/%b exp=0/0", c, if4.ready_o, if4.valid_o); end
            tick();
        end
        flush_i     = 1'b0;
        if4.valid_i = 1'b0;
        #1;
        checks++; if (count4 !== 3'd0 || empty4 !== 1'b1) begin failures++; $display("FAIL held_flush_empty got=%0d/%b exp=0/1", count4, empty4); end
        if4.ready_i = 1'b0;
    endtask

    task automatic test_depth1();
        logic [7:0] q [$];
        logic [7:0] din;
        logic       exp_ready, exp_valid, in_f, out_f;
        if1.valid_i = 1'b1;
        if1.ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if1.data_i = 8'h30 + 8'(k / 2);
            #1;
            checks++; if (if1.ready_o !== ((k % 2) == 0)) begin failures++; $display("FAIL d1_toggle[%0d] got=%b exp=%b", k, if1.ready_o, (k % 2) == 0); end
            if (k % 2 == 1) begin
                checks++; if (if1.valid_o !== 1'b1 || if1.data_o !== 8'h30 + 8'(k / 2)) begin failures++; $display("FAIL d1_data[%0d] got=%b/%0h exp=1/%0h", k, if1.valid_o, if1.data_o, 8'h30 + 8'(k / 2)); end
            end
            tick();
        end
        if1.valid_i = 1'b0;
        tick();
        for (int c = 0; c < 40; c++) begin
            din         = 8'($urandom);
            if1.valid_i = ($urandom_range(0, 1) != 0);
            if1.data_i  = din;
            if1.ready_i = ($urandom_range(0, 1) != 0);
            #1;
            exp_ready = (q.size() == 0);
            exp_valid = (q.size() != 0);
            checks++; if (if1.ready_o !== exp_ready || if1.valid_o !== exp_valid) begin failures++; $display("FAIL d1_hs[%0d] got=%b/%b exp=%b/%b", c, if1.ready_o, if1.valid_o, exp_ready, exp_valid); end
            checks++; if (count1 !== 1'(q.size()) || full1 !== exp_valid) begin failures++; $display("FAIL d1_count[%0d] got=%0d exp=%0d", c, count1, q.size()); end
            if (exp_valid) begin
                checks++; if (if1.data_o !== q[0]) begin failures++; $display("FAIL d1_rdata[%0d] got=%0h exp=%0h", c, if1.data_o, q[0]); end
            end
            in_f  = if1.valid_i & exp_ready;
            out_f = exp_valid & if1.ready_i;
            tick();
            if (out_f) void'(q.pop_front());
            if (in_f) q.push_back(din);
        end
        if1.valid_i = 1'b0;
        if1.ready_i = 1'b0;
    endtask

    initial begin
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        if4.valid_i = 1'b0; if4.ready_i = 1'b0; if4.data_i = '0;
        if3.valid_i = 1'b0; if3.ready_i = 1'b0; if3.data_i = '0;
        if1.valid_i = 1'b0; if1.ready_i = 1'b0; if1.data_i = '0;

        test_reset();
        test_fill_full();
        test_stream();
        test_wrap_d3();
        test_flush();
        test_depth1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
